// File: rtl/fetch_ctrl_if.sv
// Instruction-memory req/ack bus between fetch_ctrl (master) and the
// instruction memory (slave).
interface fetch_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one req/ack memory access per pc, holds the word for decode
// and drives StallF. Define FETCH_TIMEOUT_EN to add a REQ/DROP watchdog abort.
module fetch_ctrl #(
  parameter int          ADDR_W         = 32,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic              stall_d,
  fetch_ctrl_if.master      bus,
  output logic              ins_valid,
  output logic [31:0]       ins_out,
  output logic              StallF,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, DROP, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       ins_q, ins_d;
  logic              vld_q, vld_d;
  logic              err_q, err_d;
  logic              timeout;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("fetch_ctrl: TIMEOUT_CYCLES must be within 1..1023");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] cnt_q;

  // Counter is zero in the first REQ cycle, so the abort lands after exactly
  // TIMEOUT_CYCLES cycles of waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == REQ || state_q == DROP) begin
      cnt_q <= cnt_q + 10'd1;
    end else begin
      cnt_q <= '0;
    end
  end

  assign timeout = (state_q == REQ || state_q == DROP) && (cnt_q == TO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      ins_q   <= NOP_WORD;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ins_q   <= ins_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ins_d   = ins_q;
    vld_d   = vld_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pc[1:0] != 2'b00) begin
          err_d   = 1'b1;
          ins_d   = NOP_WORD;
          vld_d   = 1'b0;
          state_d = DONE;
        end else begin
          addr_d  = pc;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          state_d = DONE;
          ins_d   = flush ? NOP_WORD : bus.mem_rdata;
          vld_d   = !flush;
        end else if (timeout) begin
          err_d   = 1'b1;
          ins_d   = NOP_WORD;
          vld_d   = 1'b0;
          state_d = DONE;
        end else if (flush) begin
          state_d = DROP;
        end
      end
      DROP: begin
        // Request is still outstanding; its data is thrown away.
        if (bus.mem_ack) begin
          ins_d   = NOP_WORD;
          vld_d   = 1'b0;
          state_d = DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          ins_d   = NOP_WORD;
          vld_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush) vld_d = 1'b0;
        if (!stall_d) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req  = (state_q == REQ) || (state_q == DROP);
  assign bus.mem_addr = addr_q;
  assign ins_out      = ins_q;
  assign ins_valid    = vld_q && (state_q == DONE) && !flush;
  assign StallF       = (state_q != DONE) || stall_d;
  assign fetch_err    = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the fetch sequencer.
module tb_fetch_ctrl;
  localparam int          ADDR_W = 32;
  localparam int          TO     = 8;
  localparam logic [31:0] NOP    = 32'h0000_0000;
`ifdef FETCH_TIMEOUT_EN
  localparam bit TIMEOUT_EN   = 1'b1;
  localparam int RAND_LAT_MAX = 11;
`else
  localparam bit TIMEOUT_EN   = 1'b0;
  localparam int RAND_LAT_MAX = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = 32'h3000;
  logic        flush = 1'b0;
  logic        stall_d = 1'b0;
  logic        ins_valid;
  logic [31:0] ins_out;
  logic        StallF;
  logic        fetch_err;

  fetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush), .stall_d(stall_d),
    .bus(bus), .ins_valid(ins_valid), .ins_out(ins_out),
    .StallF(StallF), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a fetch is either waiting on memory, holding a word for decode,
  // or neither (about to sample pc).
  logic        m_wait, m_killed, m_hold, m_valid, m_err;
  logic [31:0] m_word, m_addr;
  int          m_cnt;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_wait <= 1'b0; m_killed <= 1'b0; m_hold <= 1'b0; m_valid <= 1'b0;
      m_err <= 1'b0; m_word <= NOP; m_addr <= '0; m_cnt <= 0;
    end else if (m_hold) begin
      if (!stall_d) begin
        m_hold <= 1'b0; m_valid <= 1'b0;
      end else if (flush) begin
        m_valid <= 1'b0;
      end
    end else if (!m_wait) begin
      if (pc[1:0] != 2'b00) begin
        m_err <= 1'b1; m_word <= NOP; m_valid <= 1'b0; m_hold <= 1'b1;
      end else begin
        m_addr <= pc; m_wait <= 1'b1; m_killed <= 1'b0; m_cnt <= 0;
      end
    end else if (bus.mem_ack) begin
      m_wait  <= 1'b0;
      m_hold  <= 1'b1;
      m_valid <= !(m_killed || flush);
      m_word  <= (m_killed || flush) ? NOP : bus.mem_rdata;
    end else if (TIMEOUT_EN && (m_cnt + 1 >= TO)) begin
      m_wait <= 1'b0; m_hold <= 1'b1; m_valid <= 1'b0; m_word <= NOP; m_err <= 1'b1;
    end else begin
      m_cnt <= m_cnt + 1;
      if (flush) m_killed <= 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #3;
      chk1 ("cyc_mem_req",   bus.mem_req, m_wait);
      chk32("cyc_mem_addr",  bus.mem_addr, m_addr);
      chk1 ("cyc_ins_valid", ins_valid, m_hold && m_valid && !flush);
      chk32("cyc_ins_out",   ins_out, m_word);
      chk1 ("cyc_StallF",    StallF, !m_hold || stall_d);
      chk1 ("cyc_fetch_err", fetch_err, m_err);
    end
  end

  // Stimulus state: IFU pc stepping and memory responder.
  bit          last_stallf = 1'b1;
  bit          pc_force_en = 1'b0;
  logic [31:0] pc_force = '0;
  bit          rand_mode = 1'b0;
  int          fixed_lat = 0;
  logic [31:0] fixed_data = '0;
  bit          stray_ack = 1'b0;
  bit          req_seen = 1'b0;
  int          lat_cnt = 0;

  function automatic logic [31:0] next_pc(input logic [31:0] p);
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return {p[31:2], 2'b00} + 32'd6;
    if (r < 4)  return $urandom & 32'hFFFF_FFFC;
    return {p[31:2], 2'b00} + 32'd4;
  endfunction

  task automatic tick(input bit f, input bit s, input bit r);
    @(negedge clk);
    reset = r;
    if (!last_stallf) begin
      if (pc_force_en) begin
        pc = pc_force;
        pc_force_en = 1'b0;
      end else begin
        pc = next_pc(pc);
      end
    end
    if (bus.mem_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        lat_cnt = rand_mode ? $urandom_range(0, RAND_LAT_MAX) : fixed_lat;
      end
      if (lat_cnt == 0) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rand_mode ? $urandom : fixed_data;
        req_seen = 1'b0;
      end else begin
        lat_cnt--;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = $urandom;
      end
    end else begin
      req_seen = 1'b0;
      bus.mem_ack = rand_mode ? ($urandom_range(0, 9) == 0) : stray_ack;
      bus.mem_rdata = $urandom;
    end
    flush = f;
    stall_d = s;
    #4;
    last_stallf = StallF;
  endtask

  initial begin
    int n;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    #1 reset = 1'b0;

    // Reset state
    tick(0, 0, 0);
    tick(0, 0, 0);
    chk1 ("rst_mem_req", bus.mem_req, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk1 ("rst_ins_valid", ins_valid, 1'b0);
    chk32("rst_ins_out", ins_out, 32'h0);
    chk1 ("rst_fetch_err", fetch_err, 1'b0);

    // Zero-wait fetch at 0x3000
    fixed_lat = 0; fixed_data = 32'h8C01_0004;
    tick(0, 0, 1);
    chk1 ("t1_idle_req", bus.mem_req, 1'b0);
    tick(0, 0, 1);
    chk1 ("t1_req", bus.mem_req, 1'b1);
    chk32("t1_addr", bus.mem_addr, 32'h3000);
    tick(0, 0, 1);
    chk1 ("t1_valid", ins_valid, 1'b1);
    chk32("t1_ins", ins_out, 32'h8C01_0004);
    chk1 ("t1_stallf", StallF, 1'b0);

    // Ack on the 4th REQ cycle
    pc_force = 32'h3004; pc_force_en = 1'b1;
    fixed_lat = 3; fixed_data = 32'hA5A5_0001;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 1);
      if (StallF) n++;
    end
    chk32("t2_stall_cycles", n, 32'd5);
    tick(0, 0, 1);
    chk1 ("t2_done_stallf", StallF, 1'b0);
    chk32("t2_ins", ins_out, 32'hA5A5_0001);

    // Flush in second REQ cycle, ack two cycles later
    pc_force = 32'h3008; pc_force_en = 1'b1;
    fixed_lat = 3; fixed_data = 32'h1234_5678;
    tick(0, 0, 1);
    chk1 ("t2_one_done", StallF, 1'b1);
    tick(0, 0, 1);
    tick(1, 0, 1);
    tick(0, 0, 1);
    chk1 ("t3_drop_req", bus.mem_req, 1'b1);
    chk1 ("t3_drop_stallf", StallF, 1'b1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk1 ("t3_valid", ins_valid, 1'b0);
    chk32("t3_ins", ins_out, 32'h0);

    // Decode stall holds the word
    pc_force = 32'h300C; pc_force_en = 1'b1;
    fixed_lat = 0; fixed_data = 32'hDEAD_BEEF;
    tick(0, 0, 1);
    tick(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 1);
      chk32("t4_hold_ins", ins_out, 32'hDEAD_BEEF);
      chk1 ("t4_hold_stallf", StallF, 1'b1);
      chk1 ("t4_hold_req", bus.mem_req, 1'b0);
    end
    pc_force = 32'h3002; pc_force_en = 1'b1;
    tick(0, 0, 1);
    chk1 ("t4_release", StallF, 1'b0);
    tick(0, 0, 1);
    chk1 ("t4_idle_valid", ins_valid, 1'b0);

    // Misaligned pc, then reset mid-REQ and a stale ack in IDLE
    tick(0, 0, 1);
    chk1 ("t5_mis_req", bus.mem_req, 1'b0);
    chk1 ("t5_mis_err", fetch_err, 1'b1);
    chk32("t5_mis_ins", ins_out, 32'h0);
    pc_force = 32'h3010; pc_force_en = 1'b1;
    fixed_lat = 10;
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk32("t5_req_addr", bus.mem_addr, 32'h3010);
    tick(0, 0, 0);
    chk1 ("t5_rst_req", bus.mem_req, 1'b0);
    chk1 ("t5_rst_err", fetch_err, 1'b0);
    chk32("t5_rst_addr", bus.mem_addr, 32'h0);
    stray_ack = 1'b1;
    tick(0, 0, 1);
    stray_ack = 1'b0;
    fixed_lat = 0; fixed_data = 32'h0000_1111;
    tick(0, 0, 1);
    chk1 ("t5_req_again", bus.mem_req, 1'b1);
    chk32("t5_stale_ignored", ins_out, 32'h0);
    tick(0, 0, 1);
    chk32("t5_ins", ins_out, 32'h0000_1111);

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers
    pc_force = 32'h3020; pc_force_en = 1'b1;
    fixed_lat = 2000;
    tick(0, 0, 1);
    n = 0;
    for (int i = 0; i < TO; i++) begin
      tick(0, 0, 1);
      if (bus.mem_req) n++;
    end
    chk32("t6_req_cycles", n, TO);
    tick(0, 1, 1);
    chk1 ("t6_req_dropped", bus.mem_req, 1'b0);
    chk1 ("t6_err", fetch_err, 1'b1);
    chk1 ("t6_valid", ins_valid, 1'b0);
    chk32("t6_ins", ins_out, 32'h0);
    tick(0, 0, 1);
`endif

    // Randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 299) != 0);
    end
    tick(0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences instruction fetch between the IFU program counter and a multi-cycle instruction memory that uses a req/ack handshake.
- Issues one memory request per PC value and holds the returned instruction for decode.
- Generates StallF so the IFU holds pc until the fetched word has been consumed.
- Handles pipeline flushes by discarding in-flight responses.

Parameters:
- ADDR_W, 32, width of pc and mem_addr.
- TIMEOUT_CYCLES, 255, cycles in REQ/DROP before abort; used only when FETCH_TIMEOUT_EN is defined; range 1..1023.
- NOP_WORD, 32'h0000_0000, instruction placed on ins_out for flushed, aborted or misaligned fetches.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current IFU program counter; stable while StallF=1.
- flush  in  1  kill current fetch (taken branch/jump resolved downstream).
- stall_d  in  1  decode stage cannot accept an instruction this cycle.
- mem_req  out  1  instruction memory request.
- mem_addr  out  ADDR_W  request address, word aligned.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  32  returned instruction word.
- ins_valid  out  1  ins_out holds a valid instruction.
- ins_out  out  32  instruction to decode.
- StallF  out  1  hold IFU pc (connects to the IFU StallF input).
- fetch_err  out  1  sticky error flag (misaligned fetch or timeout).

Behaviour:
- States: IDLE, REQ, DROP, DONE. All state bits are registers.
- Reset (reset=0, asynchronous):
  - state=IDLE, mem_req=0, mem_addr=0, ins_valid=0, ins_out=NOP_WORD, fetch_err=0, kill and timeout counter cleared.
  - mem_ack received while in IDLE is ignored. This covers a stale ack after reset mid-transaction.
- IDLE:
  - Next edge: go to REQ and set mem_addr<=pc.
  - If pc[1:0]!=0: no request is issued; set fetch_err=1, ins_out<=NOP_WORD, go to DONE.
- REQ:
  - Outputs: mem_req=1, StallF=1, ins_valid=0.
  - mem_ack and flush both 0: stay in REQ.
  - mem_ack=1 and flush=0: ins_out<=mem_rdata, go to DONE.
  - mem_ack=1 and flush=1 in the same cycle: discard the data, ins_out<=NOP_WORD, go to DONE. ins_valid is 0 in DONE for a flushed fetch.
  - flush=1 without mem_ack: go to DROP. mem_req stays 1 because the request is already outstanding.
- DROP:
  - Outputs: mem_req=1, StallF=1.
  - On mem_ack: discard mem_rdata, ins_out<=NOP_WORD, go to DONE with ins_valid=0.
  - Further flush pulses have no effect.
- DONE:
  - Outputs: mem_req=0, ins_valid as set on entry. StallF=stall_d (combinational).
  - stall_d=1: hold ins_out and ins_valid, stay in DONE.
  - stall_d=0: the IFU advances pc on this edge; go to IDLE. The next pc is latched one cycle later, so there is no combinational path from pc to mem_addr.
  - flush in DONE: clear ins_valid the same cycle (combinational mask) and on the next edge.
- StallF equation: StallF = (state!=DONE) | stall_d.
- Latency: with a zero-wait memory (ack in the first REQ cycle), the sequence IDLE->REQ->DONE->IDLE repeats every 3 cycles. Each extra memory wait cycle adds 1 cycle.
- Only one request is ever outstanding. mem_addr is stable from REQ entry until the ack.
- fetch_err is cleared only by reset.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A 10-bit counter clears on entry to REQ and increments each cycle spent in REQ or DROP.
  - When the counter reaches TIMEOUT_CYCLES without mem_ack: set fetch_err=1, ins_out<=NOP_WORD, go to DONE with ins_valid=0, drop mem_req.
  - A late ack after the abort is ignored if it arrives in DONE or IDLE.
- Undefined: no counter; REQ and DROP wait indefinitely; fetch_err is set only by misalignment.

Test Plan:
1. Reset release with pc=0x3000, ack in the first REQ cycle, mem_rdata=0x8C010004 -> mem_addr=0x3000; DONE next cycle with ins_valid=1, ins_out=0x8C010004, StallF=0.
2. pc=0x3004, ack delayed 4 cycles, stall_d=0 -> StallF=1 for 5 cycles (IDLE + 4 REQ), then exactly one DONE cycle with StallF=0.
3. flush pulse in the second REQ cycle, ack two cycles later with data 0x12345678 -> ins_valid stays 0, ins_out=0x00000000, state passes through DROP.
4. Instruction in DONE with stall_d=1 for 3 cycles -> ins_out stable, StallF=1, mem_req=0; release -> IDLE on the next edge.
5. pc=0x3002 -> no mem_req, fetch_err=1, ins_out=0x00000000. Drive reset low for 1 cycle mid-REQ -> all outputs return to reset values; an ack arriving in IDLE is ignored.
6. With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never acks -> after 8 REQ cycles fetch_err=1, mem_req=0, DONE with ins_valid=0.
